// File: rtl/emu_mem_pkg.sv
// Shared definitions for the emulation data memory: RISC-V width codes,
// FSM states, response record and access decode helpers.
package emu_mem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } state_t;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    // Access size in bytes; 0 marks a funct3 that is undefined for the direction.
    function automatic logic [2:0] access_size(input logic we, input logic [2:0] f3);
        logic [2:0] size;
        case (f3)
            F3_B:    size = 3'd1;
            F3_H:    size = 3'd2;
            F3_W:    size = 3'd4;
            F3_BU:   size = we ? 3'd0 : 3'd1;
            F3_HU:   size = we ? 3'd0 : 3'd2;
            default: size = 3'd0;
        endcase
        return size;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        case (f3)
            F3_B:    r = {{24{d[7]}}, d[7:0]};
            F3_H:    r = {{16{d[15]}}, d[15:0]};
            F3_BU:   r = {24'b0, d[7:0]};
            F3_HU:   r = {16'b0, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/emu_dmem_if.sv
// Request/response bus of the emulation data memory.
interface emu_dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/emu_dmem_bank.sv
// Word storage with per-byte write enables and a registered read port.
module emu_dmem_bank #(
    parameter int DEPTH_LOG2 = 16
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_word,
    input  logic [3:0]            wr_be,
    input  logic [31:0]           wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_word,
    output logic [31:0]           rd_data
);

    logic [31:0] mem_q [2**DEPTH_LOG2];
    logic [31:0] rd_data_q;

    // Contents are deliberately not reset so they survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[wr_word][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
        rd_data_q <= mem_q[rd_word];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/emu_dmem.sv
// Emulation data memory: byte/half/word loads and stores with optional
// two-beat handling of word-crossing accesses and a fixed-latency response.
module emu_dmem #(
    parameter int DEPTH_LOG2     = 16,
    parameter int RD_LATENCY     = 1,
    parameter int MISALIGN_SPLIT = 1
) (
    input  logic       clk,
    input  logic       rstn,
    emu_dmem_if.slave  bus
);
    import emu_mem_pkg::*;

    localparam int AW = DEPTH_LOG2;

    logic [AW-1:0] req_word;
    logic [1:0]    req_off;
    logic [2:0]    req_size;
    logic [3:0]    size_mask;
    logic [7:0]    be8;
    logic [63:0]   wd64;
    logic          req_cross, req_err, req_split, accept;

    assign req_word  = bus.req_addr[AW+1:2];
    assign req_off   = bus.req_addr[1:0];
    assign req_size  = access_size(bus.req_we, bus.req_funct3);
    assign req_cross = (({1'b0, req_off} + req_size) > 3'd4);
    assign req_err   = (req_size == 3'd0) || (|bus.req_addr[31:AW+2])
                     || (req_cross && (MISALIGN_SPLIT == 0));
    assign req_split = req_cross && !req_err;
    assign accept    = bus.req_valid && bus.req_ready;
    assign size_mask = (req_size == 3'd1) ? 4'b0001 :
                       (req_size == 3'd2) ? 4'b0011 : 4'b1111;
    assign be8       = {4'b0, size_mask} << req_off;
    assign wd64      = {32'b0, bus.req_wdata} << {req_off, 3'b000};

    state_t        state_q, state_d;
    logic          ready_q, ready_d;
    logic          s0_valid_q, s0_valid_d, s0_err_q, s0_err_d;
    logic          s0_load_q, s0_load_d, s0_split_q, s0_split_d;
    logic [2:0]    s0_f3_q, s0_f3_d;
    logic [1:0]    s0_off_q, s0_off_d;
    logic [31:0]   lo_q, lo_d;
    logic          sp_we_q, sp_we_d;
    logic [3:0]    sp_be_q, sp_be_d;
    logic [31:0]   sp_wdata_q, sp_wdata_d;
    logic [AW-1:0] sp_word_q, sp_word_d;
    logic [2:0]    sp_f3_q, sp_f3_d;
    logic [1:0]    sp_off_q, sp_off_d;

    logic          wr_en;
    logic [AW-1:0] wr_word, rd_word;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data, bank_rdata;

    emu_dmem_bank #(.DEPTH_LOG2(AW)) u_bank (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_word (wr_word),
        .wr_be   (wr_be),
        .wr_data (wr_data),
        .rd_word (rd_word),
        .rd_data (bank_rdata)
    );

    // Stage 0 describes the access whose bank data is visible this cycle;
    // a split access only becomes visible once its second beat has been read.
    always_comb begin
        state_d    = state_q;
        ready_d    = 1'b1;
        s0_valid_d = 1'b0;
        s0_err_d   = 1'b0;
        s0_load_d  = 1'b0;
        s0_split_d = 1'b0;
        s0_f3_d    = s0_f3_q;
        s0_off_d   = s0_off_q;
        lo_d       = lo_q;
        sp_we_d    = sp_we_q;
        sp_be_d    = sp_be_q;
        sp_wdata_d = sp_wdata_q;
        sp_word_d  = sp_word_q;
        sp_f3_d    = sp_f3_q;
        sp_off_d   = sp_off_q;
        wr_en      = 1'b0;
        wr_word    = req_word;
        wr_be      = be8[3:0];
        wr_data    = wd64[31:0];
        rd_word    = req_word;
        case (state_q)
            ST_IDLE: begin
                wr_en = accept && bus.req_we && !req_err;
                if (accept) begin
                    if (req_split) begin
                        state_d    = ST_SPLIT;
                        sp_we_d    = bus.req_we;
                        sp_be_d    = be8[7:4];
                        sp_wdata_d = wd64[63:32];
                        sp_word_d  = req_word + {{(AW-1){1'b0}}, 1'b1};
                        sp_f3_d    = bus.req_funct3;
                        sp_off_d   = req_off;
                    end else begin
                        s0_valid_d = 1'b1;
                        s0_err_d   = req_err;
                        s0_load_d  = !bus.req_we && !req_err;
                        s0_f3_d    = bus.req_funct3;
                        s0_off_d   = req_off;
                    end
                end
            end
            ST_SPLIT: begin
                state_d    = ST_IDLE;
                s0_valid_d = 1'b1;
                s0_load_d  = !sp_we_q;
                s0_split_d = 1'b1;
                s0_f3_d    = sp_f3_q;
                s0_off_d   = sp_off_q;
                lo_d       = bank_rdata;
                wr_en      = sp_we_q;
                wr_word    = sp_word_q;
                wr_be      = sp_be_q;
                wr_data    = sp_wdata_q;
                rd_word    = sp_word_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b0;
            s0_valid_q <= 1'b0;
            s0_err_q   <= 1'b0;
            s0_load_q  <= 1'b0;
            s0_split_q <= 1'b0;
            s0_f3_q    <= 3'b0;
            s0_off_q   <= 2'b0;
            lo_q       <= 32'b0;
            sp_we_q    <= 1'b0;
            sp_be_q    <= 4'b0;
            sp_wdata_q <= 32'b0;
            sp_word_q  <= '0;
            sp_f3_q    <= 3'b0;
            sp_off_q   <= 2'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            s0_valid_q <= s0_valid_d;
            s0_err_q   <= s0_err_d;
            s0_load_q  <= s0_load_d;
            s0_split_q <= s0_split_d;
            s0_f3_q    <= s0_f3_d;
            s0_off_q   <= s0_off_d;
            lo_q       <= lo_d;
            sp_we_q    <= sp_we_d;
            sp_be_q    <= sp_be_d;
            sp_wdata_q <= sp_wdata_d;
            sp_word_q  <= sp_word_d;
            sp_f3_q    <= sp_f3_d;
            sp_off_q   <= sp_off_d;
        end
    end

    assign bus.req_ready = ready_q && (state_q == ST_IDLE);

    logic [63:0] merged;
    logic [31:0] shifted;
    rsp_t        fmt, rsp_out;

    assign merged      = s0_split_q ? {bank_rdata, lo_q} : {32'b0, bank_rdata};
    assign shifted     = 32'(merged >> {s0_off_q, 3'b000});
    assign fmt.valid   = s0_valid_q;
    assign fmt.err     = s0_valid_q && s0_err_q;
    assign fmt.rdata   = (s0_valid_q && s0_load_q) ? load_extend(s0_f3_q, shifted) : 32'b0;

    // The registered bank read already provides one cycle of latency.
    if (RD_LATENCY <= 1) begin : g_direct
        assign rsp_out = fmt;
    end else begin : g_pipe
        rsp_t pipe_q [RD_LATENCY-1];
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int i = 0; i < RD_LATENCY-1; i++) pipe_q[i] <= '0;
            end else begin
                pipe_q[0] <= fmt;
                for (int i = 1; i < RD_LATENCY-1; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end
        assign rsp_out = pipe_q[RD_LATENCY-2];
    end

    assign bus.rsp_valid = rsp_out.valid;
    assign bus.rsp_err   = rsp_out.err;
    assign bus.rsp_rdata = rsp_out.rdata;

endmodule

// File: tb/tb_emu_dmem.sv
// Scoreboard bench for emu_dmem: instance A splits word-crossing accesses with
// a three-cycle latency, instance B flags them as errors with unit latency.
module tb_emu_dmem;
    import emu_mem_pkg::*;

    localparam bit DA = 1'b0;
    localparam bit DB = 1'b1;
    localparam bit LD = 1'b0;
    localparam bit ST = 1'b1;
    localparam int LAT_A = 3;
    localparam int LAT_B = 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    emu_dmem_if bus_a();
    emu_dmem_if bus_b();

    emu_dmem #(.DEPTH_LOG2(10), .RD_LATENCY(LAT_A), .MISALIGN_SPLIT(1)) dut_a (
        .clk(clk), .rstn(rstn), .bus(bus_a.slave)
    );
    emu_dmem #(.DEPTH_LOG2(10), .RD_LATENCY(LAT_B), .MISALIGN_SPLIT(0)) dut_b (
        .clk(clk), .rstn(rstn), .bus(bus_b.slave)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: actual 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    // Presents one request, waits (bounded) for acceptance, then queues the expected response.
    task automatic applyStimulus(input bit sel, input bit we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input bit exp_err,
                                 input bit split, input string name);
        bit   got = 1'b0;
        exp_t e;
        if (sel == DA) begin
            bus_a.req_valid = 1'b1; bus_a.req_we = we; bus_a.req_funct3 = f3;
            bus_a.req_addr = addr; bus_a.req_wdata = wdata;
        end else begin
            bus_b.req_valid = 1'b1; bus_b.req_we = we; bus_b.req_funct3 = f3;
            bus_b.req_addr = addr; bus_b.req_wdata = wdata;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (sel == DA) ? bus_a.req_ready : bus_b.req_ready;
        end
        checkOutput({name, "_accept"}, {31'b0, got}, 32'd1);
        if (got) begin
            @(posedge clk);
            #1;
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.cyc   = cyc + ((sel == DA) ? LAT_A : LAT_B) - 1 + int'(split);
            e.name  = name;
            if (sel == DA) qa.push_back(e);
            else qb.push_back(e);
        end
        if (sel == DA) bus_a.req_valid = 1'b0;
        else bus_b.req_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus_a.rsp_valid) begin
            if (qa.size() == 0) begin
                checkOutput("a_unexpected_rsp", {31'b0, bus_a.rsp_valid}, 32'd0);
            end else begin
                e = qa.pop_front();
                checkOutput({e.name, "_rdata"}, bus_a.rsp_rdata, e.rdata);
                checkOutput({e.name, "_err"}, {31'b0, bus_a.rsp_err}, {31'b0, e.err});
                checkOutput({e.name, "_cycle"}, cyc, e.cyc);
            end
        end else begin
            checkOutput("a_idle_zero", {bus_a.rsp_rdata[31:1], bus_a.rsp_rdata[0] | bus_a.rsp_err}, 32'd0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus_b.rsp_valid) begin
            if (qb.size() == 0) begin
                checkOutput("b_unexpected_rsp", {31'b0, bus_b.rsp_valid}, 32'd0);
            end else begin
                e = qb.pop_front();
                checkOutput({e.name, "_rdata"}, bus_b.rsp_rdata, e.rdata);
                checkOutput({e.name, "_err"}, {31'b0, bus_b.rsp_err}, {31'b0, e.err});
                checkOutput({e.name, "_cycle"}, cyc, e.cyc);
            end
        end else begin
            checkOutput("b_idle_zero", {bus_b.rsp_rdata[31:1], bus_b.rsp_rdata[0] | bus_b.rsp_err}, 32'd0);
        end
    end

    initial begin
        bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_funct3 = 3'd0;
        bus_a.req_addr = 32'd0; bus_a.req_wdata = 32'd0;
        bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_funct3 = 3'd0;
        bus_b.req_addr = 32'd0; bus_b.req_wdata = 32'd0;

        $display("[TB] reset phase");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready_a", {31'b0, bus_a.req_ready}, 32'd0);
        checkOutput("rst_ready_b", {31'b0, bus_b.req_ready}, 32'd0);
        checkOutput("rst_valid_a", {31'b0, bus_a.rsp_valid}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checkOutput("rel_ready_before_edge", {31'b0, bus_a.req_ready}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rel_ready_a", {31'b0, bus_a.req_ready}, 32'd1);
        checkOutput("rel_ready_b", {31'b0, bus_b.req_ready}, 32'd1);

        $display("[TB] instance A: byte/half extension, byte lanes");
        applyStimulus(DA, ST, F3_W,  32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, "a_sw100");
        applyStimulus(DA, LD, F3_B,  32'h103, 32'h0,        32'hFFFFFFDE, 1'b0, 1'b0, "a_lb103");
        applyStimulus(DA, LD, F3_BU, 32'h103, 32'h0,        32'h000000DE, 1'b0, 1'b0, "a_lbu103");
        applyStimulus(DA, LD, F3_H,  32'h102, 32'h0,        32'hFFFFDEAD, 1'b0, 1'b0, "a_lh102");
        applyStimulus(DA, LD, F3_HU, 32'h102, 32'h0,        32'h0000DEAD, 1'b0, 1'b0, "a_lhu102");
        applyStimulus(DA, ST, F3_W,  32'h200, 32'h11223344, 32'h0,        1'b0, 1'b0, "a_sw200");
        applyStimulus(DA, ST, F3_B,  32'h201, 32'hFFFFFFAA, 32'h0,        1'b0, 1'b0, "a_sb201");
        applyStimulus(DA, LD, F3_W,  32'h200, 32'h0,        32'h1122AA44, 1'b0, 1'b0, "a_lw200");

        $display("[TB] instance A: split accesses");
        applyStimulus(DA, ST, F3_W,  32'h300, 32'h44332211, 32'h0,        1'b0, 1'b0, "a_sw300");
        applyStimulus(DA, ST, F3_W,  32'h304, 32'h88776655, 32'h0,        1'b0, 1'b0, "a_sw304");
        applyStimulus(DA, LD, F3_W,  32'h302, 32'h0,        32'h66554433, 1'b0, 1'b1, "a_lw302_split");
        checkOutput("a_split_ready_low", {31'b0, bus_a.req_ready}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("a_split_ready_back", {31'b0, bus_a.req_ready}, 32'd1);
        applyStimulus(DA, ST, F3_H,  32'h303, 32'h1234CAFE, 32'h0,        1'b0, 1'b1, "a_sh303_split");
        applyStimulus(DA, LD, F3_W,  32'h300, 32'h0,        32'hFE332211, 1'b0, 1'b0, "a_lw300_after");
        applyStimulus(DA, LD, F3_W,  32'h304, 32'h0,        32'h887766CA, 1'b0, 1'b0, "a_lw304_after");
        applyStimulus(DA, ST, F3_W,  32'hFFC, 32'hA1B2C3D4, 32'h0,        1'b0, 1'b0, "a_sw_top");
        applyStimulus(DA, ST, F3_W,  32'h000, 32'h55667788, 32'h0,        1'b0, 1'b0, "a_sw0");
        applyStimulus(DA, LD, F3_W,  32'hFFE, 32'h0,        32'h7788A1B2, 1'b0, 1'b1, "a_lw_wrap");

        $display("[TB] instance A: errors");
        applyStimulus(DA, LD, F3_W,  32'h1000, 32'h0,       32'h0,        1'b1, 1'b0, "a_range_err");
        applyStimulus(DA, LD, 3'd3,  32'h100, 32'h0,        32'h0,        1'b1, 1'b0, "a_ld_f3_3");
        applyStimulus(DA, LD, 3'd6,  32'h100, 32'h0,        32'h0,        1'b1, 1'b0, "a_ld_f3_6");
        applyStimulus(DA, ST, 3'd3,  32'h100, 32'h0,        32'h0,        1'b1, 1'b0, "a_st_f3_3");
        applyStimulus(DA, ST, F3_BU, 32'h100, 32'h0,        32'h0,        1'b1, 1'b0, "a_st_f3_4");

        $display("[TB] instance A: back-to-back loads");
        applyStimulus(DA, LD, F3_W,  32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, "a_b2b_0");
        applyStimulus(DA, LD, F3_W,  32'h200, 32'h0,        32'h1122AA44, 1'b0, 1'b0, "a_b2b_1");
        applyStimulus(DA, LD, F3_W,  32'h300, 32'h0,        32'hFE332211, 1'b0, 1'b0, "a_b2b_2");
        applyStimulus(DA, LD, F3_W,  32'h304, 32'h0,        32'h887766CA, 1'b0, 1'b0, "a_b2b_3");
        repeat (10) @(posedge clk);
        #1;

        $display("[TB] instance B: misaligned accesses flagged");
        applyStimulus(DB, ST, F3_W,  32'h3FC, 32'h12345678, 32'h0,        1'b0, 1'b0, "b_sw3fc");
        applyStimulus(DB, ST, F3_W,  32'h400, 32'h9ABCDEF0, 32'h0,        1'b0, 1'b0, "b_sw400");
        applyStimulus(DB, ST, F3_H,  32'h3FF, 32'h0000BEEF, 32'h0,        1'b1, 1'b0, "b_sh3ff_err");
        checkOutput("b_err_ready_stays", {31'b0, bus_b.req_ready}, 32'd1);
        applyStimulus(DB, LD, F3_W,  32'h3FC, 32'h0,        32'h12345678, 1'b0, 1'b0, "b_lw3fc");
        applyStimulus(DB, LD, F3_W,  32'h400, 32'h0,        32'h9ABCDEF0, 1'b0, 1'b0, "b_lw400");
        applyStimulus(DB, LD, F3_B,  32'h3FD, 32'h0,        32'h00000056, 1'b0, 1'b0, "b_lb3fd");
        applyStimulus(DB, LD, F3_H,  32'h3FD, 32'h0,        32'h00003456, 1'b0, 1'b0, "b_lh3fd");
        applyStimulus(DB, LD, F3_HU, 32'h3FE, 32'h0,        32'h00001234, 1'b0, 1'b0, "b_lhu3fe");
        applyStimulus(DB, LD, F3_B,  32'h400, 32'h0,        32'hFFFFFFF0, 1'b0, 1'b0, "b_lb400");
        applyStimulus(DB, LD, F3_H,  32'h3FF, 32'h0,        32'h0,        1'b1, 1'b0, "b_lh3ff_err");
        applyStimulus(DB, LD, F3_W,  32'h402, 32'h0,        32'h0,        1'b1, 1'b0, "b_lw402_err");
        repeat (10) @(posedge clk);
        #1;

        $display("[TB] reset during split");
        bus_a.req_valid = 1'b1; bus_a.req_we = LD; bus_a.req_funct3 = F3_W;
        bus_a.req_addr = 32'h302; bus_a.req_wdata = 32'h0;
        @(negedge clk);
        checkOutput("rs_ready_before", {31'b0, bus_a.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus_a.req_valid = 1'b0;
        checkOutput("rs_in_split", {31'b0, bus_a.req_ready}, 32'd0);
        rstn = 1'b0;
        #1;
        checkOutput("rs_ready_low", {31'b0, bus_a.req_ready}, 32'd0);
        checkOutput("rs_valid_low", {31'b0, bus_a.rsp_valid}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rs_ready_after", {31'b0, bus_a.req_ready}, 32'd1);
        repeat (8) @(posedge clk);
        #1;
        applyStimulus(DA, LD, F3_W,  32'h300, 32'h0,        32'hFE332211, 1'b0, 1'b0, "a_post_reset");
        repeat (10) @(posedge clk);
        #1;

        checkOutput("a_queue_drained", qa.size(), 32'd0);
        checkOutput("b_queue_drained", qb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
